// File: rtl/cordic_nco.sv
// cordic_nco: phase accumulator plus offset feeding a fully pipelined rotation-mode CORDIC.
// Emits AMP*cos/sin of the accumulated phase ITER+2 edges after the sample is issued.

module cordic_nco_stage #(
  parameter int              DW    = 18,
  parameter int              PW    = 32,
  parameter int              SHIFT = 0,
  parameter logic [PW-1:0]   ATAN  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] xi,
  input  logic signed [DW-1:0] yi,
  input  logic        [PW-1:0] zi,
  output logic signed [DW-1:0] xo,
  output logic signed [DW-1:0] yo,
  output logic        [PW-1:0] zo
);
  // Rounded shift keeps truncation bias from accumulating across stages
  localparam logic signed [DW-1:0] RND = (SHIFT == 0) ? '0 : DW'(64'd1 << ((SHIFT > 0) ? SHIFT - 1 : 0));

  logic signed [DW-1:0] xs, ys;
  assign xs = (xi + RND) >>> SHIFT;
  assign ys = (yi + RND) >>> SHIFT;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      xo <= '0;
      yo <= '0;
      zo <= '0;
    end else if (zi[PW-1]) begin
      xo <= xi + ys;
      yo <= yi - xs;
      zo <= zi + ATAN;
    end else begin
      xo <= xi - ys;
      yo <= yi + xs;
      zo <= zi - ATAN;
    end
endmodule

module cordic_nco #(
  parameter int DWIDTH   = 16,
  parameter int PWIDTH   = 32,
  parameter int ITER     = 16,
  parameter int AMP      = 2**(DWIDTH-1) - 1,
  parameter int UPD_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     sync,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic        [PWIDTH-1:0] cfg_step,
  input  logic        [PWIDTH-1:0] cfg_offset,
  output logic                     out_valid,
  output logic signed [DWIDTH-1:0] cos,
  output logic signed [DWIDTH-1:0] sin,
  output logic        [PWIDTH-1:0] phase_out
);
  localparam int DW  = DWIDTH + 2;
  localparam int LAT = ITER + 2;

  function automatic longint atan_turn(input int i);
    real a;
    a = $atan(1.0 / (2.0 ** i)) / (2.0 * 3.14159265358979323846) * (2.0 ** PWIDTH);
    return longint'(a);
  endfunction

  // Datapath carries one fractional bit, so the start vector is 2*AMP/gain
  function automatic longint start_mag();
    real g;
    g = 1.0;
    for (int i = 0; i < ITER; i++) g = g * $sqrt(1.0 + 1.0 / (4.0 ** i));
    return longint'(2.0 * AMP / g);
  endfunction

  localparam logic signed [DW-1:0] X0   = DW'(start_mag());
  localparam logic signed [DW-1:0] AMPS = DW'(AMP);
  localparam logic signed [DW-1:0] ONE  = 1;

  logic [PWIDTH-1:0] acc, step, offset, sh_step, sh_offset;
  logic              pend;
  logic [PWIDTH:0]   sum;
  logic              wrap, take_cfg, apply;

  assign sum       = {1'b0, acc} + {1'b0, step};
  assign wrap      = en & sum[PWIDTH];
  assign cfg_ready = (UPD_MODE == 0) ? 1'b1 : ~pend;
  assign take_cfg  = cfg_valid & cfg_ready;
  assign apply     = (UPD_MODE != 0) && pend && (sync || wrap);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc       <= '0;
      step      <= '0;
      offset    <= '0;
      sh_step   <= '0;
      sh_offset <= '0;
      pend      <= 1'b0;
    end else begin
      if (sync)    acc <= '0;
      else if (en) acc <= sum[PWIDTH-1:0];
      if (UPD_MODE == 0) begin
        if (take_cfg) begin
          step   <= cfg_step;
          offset <= cfg_offset;
        end
      end else begin
        if (take_cfg) begin
          sh_step   <= cfg_step;
          sh_offset <= cfg_offset;
          pend      <= 1'b1;
        end
        if (apply) begin
          step   <= sh_step;
          offset <= sh_offset;
          pend   <= 1'b0;
        end
      end
    end

  logic [LAT:0]        vld_pipe;
  logic [PWIDTH-1:0]   ph_pipe [LAT];
  logic signed [DW-1:0] x0;
  logic [PWIDTH-1:0]   z0;
  logic                flip;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < LAT; i++) ph_pipe[i] <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[LAT-1:0], en};
      ph_pipe[0] <= acc + offset;
      for (int i = 1; i < LAT; i++) ph_pipe[i] <= ph_pipe[i-1];
    end

  // Quadrants 1/2: start from -x0 and rotate by phi-pi, keeping the residual within +-1/4 turn
  assign flip = ph_pipe[0][PWIDTH-1] ^ ph_pipe[0][PWIDTH-2];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x0 <= '0;
      z0 <= '0;
    end else begin
      x0 <= flip ? -X0 : X0;
      z0 <= {ph_pipe[0][PWIDTH-1] ^ flip, ph_pipe[0][PWIDTH-2:0]};
    end

  logic signed [DW-1:0] xr [ITER+1];
  logic signed [DW-1:0] yr [ITER+1];
  logic [PWIDTH-1:0]    zr [ITER+1];

  assign xr[0] = x0;
  assign yr[0] = '0;
  assign zr[0] = z0;

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    cordic_nco_stage #(
      .DW(DW), .PW(PWIDTH), .SHIFT(i), .ATAN(PWIDTH'(atan_turn(i)))
    ) u_stage (
      .clk(clk), .rst(rst),
      .xi(xr[i]), .yi(yr[i]), .zi(zr[i]),
      .xo(xr[i+1]), .yo(yr[i+1]), .zo(zr[i+1])
    );
  end

  function automatic logic signed [DWIDTH-1:0] sat(input logic signed [DW-1:0] v);
    if (v > AMPS)       sat = DWIDTH'(AMPS);
    else if (v < -AMPS) sat = DWIDTH'(-AMPS);
    else                sat = DWIDTH'(v);
  endfunction

  logic signed [DW-1:0] xf, yf;
  assign xf = (xr[ITER] + ONE) >>> 1;
  assign yf = (yr[ITER] + ONE) >>> 1;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cos       <= '0;
      sin       <= '0;
      phase_out <= '0;
    end else if (vld_pipe[LAT-1]) begin
      cos       <= sat(xf);
      sin       <= sat(yf);
      phase_out <= ph_pipe[LAT-1];
    end

  assign out_valid = vld_pipe[LAT];
endmodule

// File: tb/tb_cordic_nco.sv
// Scoreboard bench for cordic_nco: an immediate-update and an at-wrap-update instance.
module tb_cordic_nco;
  localparam int DW = 16, PW = 32, IT = 16, LAT = IT + 2;
  typedef struct { logic [PW-1:0] phi; int edge_no; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] en = '0, sync = '0, cfg_valid = '0;
  logic [1:0] cfg_ready, out_valid;
  logic [1:0][PW-1:0] cfg_step = '0, cfg_offset = '0;
  logic [1:0][PW-1:0] ph_o;
  logic [1:0][DW-1:0] cos_o, sin_o;

  int checks = 0, errors = 0, cyc = 0;
  logic [PW-1:0] m_acc [2], m_step [2], m_off [2], m_shs [2], m_sho [2];
  bit m_pend [2];
  exp_t q0[$], q1[$];
  // AMP*cos(k/16 turn), AMP = 32767
  int ctab [16] = '{32767, 30273, 23170, 12539, 0, -12539, -23170, -30273,
                    -32767, -30273, -23170, -12539, 0, 12539, 23170, 30273};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_nco #(.DWIDTH(DW), .PWIDTH(PW), .ITER(IT), .UPD_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en[0]), .sync(sync[0]), .cfg_valid(cfg_valid[0]),
    .cfg_ready(cfg_ready[0]), .cfg_step(cfg_step[0]), .cfg_offset(cfg_offset[0]),
    .out_valid(out_valid[0]), .cos(cos_o[0]), .sin(sin_o[0]), .phase_out(ph_o[0]));

  cordic_nco #(.DWIDTH(DW), .PWIDTH(PW), .ITER(IT), .UPD_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en[1]), .sync(sync[1]), .cfg_valid(cfg_valid[1]),
    .cfg_ready(cfg_ready[1]), .cfg_step(cfg_step[1]), .cfg_offset(cfg_offset[1]),
    .out_valid(out_valid[1]), .cos(cos_o[1]), .sin(sin_o[1]), .phase_out(ph_o[1]));

  task automatic chk(input string nm, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit near(input int a, input int b);
    return (a - b <= 3) && (b - a <= 3);
  endfunction

  task automatic mon(input int d, input exp_t e);
    int k, c, s;
    k = int'(e.phi[PW-1 -: 4]);
    c = int'($signed(cos_o[d]));
    s = int'($signed(sin_o[d]));
    chk($sformatf("phase_out%0d", d), ph_o[d] == e.phi, ph_o[d], e.phi);
    chk($sformatf("latency%0d", d), cyc - e.edge_no == LAT, cyc - e.edge_no, LAT);
    if (e.phi[PW-5:0] == '0) begin
      chk($sformatf("cos%0d", d), near(c, ctab[k]), c, ctab[k]);
      chk($sformatf("sin%0d", d), near(s, ctab[(k + 12) % 16]), s, ctab[(k + 12) % 16]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid[0]) begin
      chk("expected_sample0", q0.size() > 0, q0.size(), 1);
      if (q0.size() > 0) mon(0, q0.pop_front());
    end
    if (!rst && out_valid[1]) begin
      chk("expected_sample1", q1.size() > 0, q1.size(), 1);
      if (q1.size() > 0) mon(1, q1.pop_front());
    end
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_acc[d] = '0; m_step[d] = '0; m_off[d] = '0;
      m_shs[d] = '0; m_sho[d] = '0; m_pend[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic chk_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid%0d", d), out_valid[d] == 1'b0, out_valid[d], 0);
      chk($sformatf("rst_cos%0d", d), cos_o[d] == '0, cos_o[d], 0);
      chk($sformatf("rst_sin%0d", d), sin_o[d] == '0, sin_o[d], 0);
      chk($sformatf("rst_phase%0d", d), ph_o[d] == '0, ph_o[d], 0);
      chk($sformatf("rst_ready%0d", d), cfg_ready[d] == 1'b1, cfg_ready[d], 1);
    end
  endtask

  // One clock on DUT d; the expected sample and next model state follow the edge
  task automatic drive(input int d, input bit e, input bit s, input bit cv,
                       input logic [PW-1:0] st, input logic [PW-1:0] of);
    logic [PW:0] sum;
    bit take, apply, rdy;
    exp_t x;
    @(negedge clk);
    rdy = (d == 0) || !m_pend[d];
    chk($sformatf("cfg_ready%0d", d), cfg_ready[d] == rdy, cfg_ready[d], rdy);
    en = '0; sync = '0; cfg_valid = '0;
    en[d] = e; sync[d] = s; cfg_valid[d] = cv; cfg_step[d] = st; cfg_offset[d] = of;
    @(posedge clk);
    #1;
    if (e) begin
      x.phi = m_acc[d] + m_off[d];
      x.edge_no = cyc;
      if (d == 0) q0.push_back(x); else q1.push_back(x);
    end
    take  = cv && rdy;
    sum   = {1'b0, m_acc[d]} + {1'b0, m_step[d]};
    apply = (d == 1) && m_pend[d] && (s || (e && sum[PW]));
    if (s)      m_acc[d] = '0;
    else if (e) m_acc[d] = sum[PW-1:0];
    if (take && d == 0) begin m_step[d] = st; m_off[d] = of; end
    if (take && d == 1) begin m_shs[d] = st; m_sho[d] = of; m_pend[d] = 1'b1; end
    if (apply) begin m_step[d] = m_shs[d]; m_off[d] = m_sho[d]; m_pend[d] = 1'b0; end
  endtask

  task automatic run(input int d, input bit e, input int n);
    for (int i = 0; i < n; i++) drive(d, e, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic scen1();
    drive(0, 1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h0);
    run(0, 1'b1, 12);
    run(0, 1'b0, LAT + 2);
  endtask

  int pat [10] = '{1, 0, 1, 1, 0, 1, 0, 1, 1, 0};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    scen1();
    // offset of a quarter turn: first sample at phase 0x40000000
    drive(0, 1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h4000_0000);
    run(0, 1'b1, 6);
    run(0, 1'b0, LAT + 2);

    // gapped enable
    drive(0, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 32'h0);
    foreach (pat[i]) drive(0, pat[i] != 0, 1'b0, 1'b0, '0, '0);
    run(0, 1'b0, LAT + 2);

    // sync with en at acc=0x60000000 still emits that sample
    drive(0, 1'b0, 1'b1, 1'b1, 32'h2000_0000, 32'h0);
    run(0, 1'b1, 3);
    drive(0, 1'b1, 1'b1, 1'b0, '0, '0);
    run(0, 1'b1, 2);
    run(0, 1'b0, LAT + 2);

    // asynchronous reset mid-stream, then a clean restart
    drive(0, 1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h0);
    run(0, 1'b1, 6);
    #2;
    rst = 1'b1;
    en = '0; sync = '0; cfg_valid = '0;
    #1;
    chk_reset_outputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    scen1();

    // at-wrap update: step loaded by sync, new step requested at acc=0x20000000
    drive(1, 1'b0, 1'b0, 1'b1, 32'h2000_0000, 32'h0);
    drive(1, 1'b0, 1'b1, 1'b0, '0, '0);
    drive(1, 1'b1, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b1, 1'b0, 1'b1, 32'h0800_0000, 32'h0);
    run(1, 1'b1, 6);
    run(1, 1'b1, 3);
    // pending update applied by sync on the same edge
    drive(1, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 32'h4000_0000);
    drive(1, 1'b1, 1'b1, 1'b0, '0, '0);
    run(1, 1'b1, 3);
    run(1, 1'b0, LAT + 2);

    chk("drained0", q0.size() == 0, q0.size(), 0);
    chk("drained1", q1.size() == 0, q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
